painel_chamadas: RTL and testbench
==================================

# painel_chamadas

Call-button panel for the five-floor elevator: captures floor-button presses, holds them as pending calls and presents one locked call at a time on the controller's request lines. It watches the controller's floor and motor outputs to detect arrival, clears the served call and runs a door-open timer before dispatching the next call. It sits between the button inputs and the elevator controller's `req` input, and it is the consumer of that controller's `andar_atual`, `motor_up` and `motor_down` outputs.

## Interface
- `DOOR_CYCLES`, default 4: clock cycles the door stays open per served call; legal range ≥1.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn`  in  5  raw level button inputs; `btn[i]` is floor i.
- `andar_atual`  in  3  current floor from the controller.
- `motor_up`  in  1  controller motor-up output.
- `motor_down`  in  1  controller motor-down output.
- `req`  out  5  one-hot request to the controller; all zero when no call is dispatched.
- `door_open`  out  1  high while the door timer runs.
- `pending`  out  5  latched, unserved calls.
- `target`  out  3  locked target floor; reset value 0.

## Operation
- Edge detect:
  - `btn_q` registers `btn`.
  - A press on floor i is `btn[i] & ~btn_q[i]`.
  - A held button produces only one press.
- Latching:
  - A press sets `pending[i]`.
  - Exception: a press for `andar_atual` during DOOR is not latched and reloads the door counter instead.
- Stopped: `motor_up == 0 && motor_down == 0`.
- State machine `estado`: IDLE, DISPATCH, DOOR.
  - **IDLE**:
    - Outputs: `req = 0`, `door_open = 0`.
    - If `pending != 0`: lock `target` = lowest-index set bit of the registered `pending`, then go to DISPATCH.
    - A press in the same cycle is not considered until the next cycle.
  - **DISPATCH**:
    - Output: `req = 1 << target`.
    - If stopped and `andar_atual == target`: clear `pending[target]`, load counter with `DOOR_CYCLES-1`, then go to DOOR.
    - `target` does not change while in DISPATCH, even if lower-index calls arrive.
  - **DOOR**:
    - Outputs: `req = 0`, `door_open = 1`.
    - When counter == 0, go to IDLE; otherwise decrement the counter.
- Outputs are decoded from registers only; no input-to-output combinational path.
- Counter width is `$clog2(DOOR_CYCLES+1)`.
- Boundary rules:
  - **Clear vs. set, same cycle:** a press on floor `target` in the serve cycle loses; the bit ends up 0.
  - **Call at current floor from IDLE:** goes IDLE → DISPATCH, is served on the next cycle, then DOOR.
  - **Out-of-range floor:** `andar_atual` of 5–7 never matches, so the panel stays in DISPATCH.
  - **Multiple simultaneous presses:** all are latched in one cycle.
  - **Reset mid-operation:** any state returns to IDLE. `pending`, `btn_q`, `target` and the counter are 0; `req = 0` and `door_open = 0`.
  - **First cycle after reset:** a button already held produces a press, because `btn_q` is 0.

## Timing
- Reset values: `req = 0`, `door_open = 0`, `pending = 0`, `target = 0`.
- Press to request:
  - Button first sampled high at edge N → `pending[i] = 1` after edge N.
  - IDLE → DISPATCH at edge N+1, so `req` is valid after edge N+1.
  - Total: 2 cycles from the sampled press.
- Arrival to door:
  - Serve condition true in the cycle after edge M.
  - At edge M+1: DOOR, `pending` bit cleared, `req = 0`.
- Door timing:
  - `door_open` is high for exactly `DOOR_CYCLES` cycles.
  - Each current-floor press during DOOR extends the open time to `DOOR_CYCLES` cycles from that press.
- Dispatch after the door:
  - DOOR → IDLE, then the next dispatch one cycle later.
  - Minimum gap between successive `req` assertions: `DOOR_CYCLES+1` cycles.
- Against the controller:
  - The motors stay high in the arrival cycle, so the serve condition fires one cycle after the floor match.
  - No premature serve on the move-start cycle.

## Test plan
- Reset, press `btn[3]` with the panel wired to the elevator controller, floor 0:
  - `pending = 01000`, then `req = 01000` 2 cycles after the press.
  - Floor 3 is reached; `door_open` is high for 4 cycles, then `pending = 0` and `req = 0`.
- Press `btn[2]` and `btn[4]` in the same cycle, from floor 0:
  - Target 2 is served first, then target 4.
  - The `req` sequence is `00100`, 0 during the door, then `10000`.
- With `target` = 4 in DISPATCH, press `btn[1]`:
  - `req` stays `10000` until floor 4 is served.
  - Floor 1 is dispatched next.
- During DOOR at floor 2, press `btn[2]` on door cycle 3:
  - `door_open` stays high for 4 more cycles.
  - `pending[2]` stays 0.
- Hold `btn[1]` for 20 cycles:
  - Only one call is latched.
  - After the floor-1 service completes, `pending[1] = 0` and there is no re-dispatch.
- Assert `reset` while in DISPATCH with `pending = 10110`:
  - All outputs are 0 next cycle.
  - IDLE, with no `req` until a new press.

Source files
------------

// File: rtl/painel_chamadas.sv
// painel_chamadas: five-floor call-button panel feeding one locked call at a time to the elevator controller
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   btn[4:0]             raw level floor buttons, btn[i] is floor i
//   andar_atual[2:0]     current floor reported by the controller
//   motor_up, motor_down controller motor outputs, both low means stopped
//   req[4:0]             one-hot request for the locked target, zero when nothing is dispatched
//   door_open            high while the door timer runs
//   pending[4:0]         latched, unserved calls
//   target[2:0]          locked target floor
module painel_chamadas #(
    parameter int DOOR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn,
    input  logic [2:0] andar_atual,
    input  logic       motor_up,
    input  logic       motor_down,
    output logic [4:0] req,
    output logic       door_open,
    output logic [4:0] pending,
    output logic [2:0] target
);
    localparam int CW = $clog2(DOOR_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DOOR} estado_t;

    estado_t       estado, estado_n;
    logic [4:0]    btn_q, press, cur_mask, tgt_mask, pending_n;
    logic [2:0]    target_n, lowest;
    logic [CW-1:0] cnt, cnt_n;
    logic          serve, reload;

    always_comb begin
        lowest = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (pending[i]) lowest = 3'(i);
    end

    // Floors 5-7 shift the one out of range, so they never match any call.
    assign press    = btn & ~btn_q;
    assign cur_mask = 5'b00001 << andar_atual;
    assign tgt_mask = 5'b00001 << target;
    assign serve    = estado == DISPATCH && !motor_up && !motor_down && andar_atual == target;
    assign reload   = estado == DOOR && |(press & cur_mask);

    // A current-floor press while the door is open only extends the door; the serve clear beats a same-cycle press.
    assign pending_n = (pending | (press & ~(estado == DOOR ? cur_mask : 5'b0)))
                     & ~(serve ? tgt_mask : 5'b0);

    always_comb begin
        estado_n = estado;
        target_n = target;
        cnt_n    = cnt;
        case (estado)
            IDLE: begin
                if (|pending) begin
                    target_n = lowest;
                    estado_n = DISPATCH;
                end
            end
            DISPATCH: begin
                if (serve) begin
                    cnt_n    = LOAD;
                    estado_n = DOOR;
                end
            end
            DOOR: begin
                if (reload) cnt_n = LOAD;
                else if (cnt == '0) estado_n = IDLE;
                else cnt_n = cnt - CW'(1);
            end
            default: estado_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado  <= IDLE;
            btn_q   <= '0;
            pending <= '0;
            target  <= '0;
            cnt     <= '0;
        end else begin
            estado  <= estado_n;
            btn_q   <= btn;
            pending <= pending_n;
            target  <= target_n;
            cnt     <= cnt_n;
        end
    end

    assign req       = estado == DISPATCH ? tgt_mask : 5'b0;
    assign door_open = estado == DOOR;
endmodule

// File: tb/tb_painel_chamadas.sv
// tb_painel_chamadas: directed vector bench for the call-button panel
module tb_painel_chamadas;
    logic       clk = 0;
    logic       reset = 1;
    logic [4:0] btn = '0;
    logic [2:0] andar_atual = '0;
    logic       motor_up = 0;
    logic       motor_down = 0;
    logic [4:0] req;
    logic       door_open;
    logic [4:0] pending;
    logic [2:0] target;

    int n_chk = 0;
    int n_fail = 0;

    painel_chamadas #(.DOOR_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .andar_atual(andar_atual),
        .motor_up(motor_up),
        .motor_down(motor_down),
        .req(req),
        .door_open(door_open),
        .pending(pending),
        .target(target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] b;
        logic [2:0] fl;
        logic       mu;
        logic       md;
        logic [4:0] e_req;
        logic       e_door;
        logic [4:0] e_pend;
        logic [2:0] e_tgt;
    } vec_t;

    vec_t vecs[34];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [4:0] b, input logic [2:0] fl, input logic mu, input logic md);
        reset = r;
        btn = b;
        andar_atual = fl;
        motor_up = mu;
        motor_down = md;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [4:0] r, input logic d, input logic [4:0] p, input logic [2:0] t);
        chk({name, ".req"}, 8'(req), 8'(r));
        chk({name, ".door"}, 8'(door_open), 8'(d));
        chk({name, ".pend"}, 8'(pending), 8'(p));
        chk({name, ".tgt"}, 8'(target), 8'(t));
    endtask

    initial begin
        int dispatch_cycles;
        vecs[0]  = '{1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000, 3'd0};
        vecs[1]  = '{1'b0, 5'b01000, 3'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b01000, 3'd0};
        vecs[2]  = '{1'b0, 5'b01000, 3'd0, 1'b0, 1'b0, 5'b01000, 1'b0, 5'b01000, 3'd3};
        vecs[3]  = '{1'b0, 5'b00000, 3'd0, 1'b1, 1'b0, 5'b01000, 1'b0, 5'b01000, 3'd3};
        vecs[4]  = '{1'b0, 5'b00000, 3'd3, 1'b1, 1'b0, 5'b01000, 1'b0, 5'b01000, 3'd3};
        vecs[5]  = '{1'b0, 5'b00000, 3'd3, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 3'd3};
        vecs[6]  = '{1'b0, 5'b00000, 3'd3, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 3'd3};
        vecs[7]  = '{1'b0, 5'b00000, 3'd3, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 3'd3};
        vecs[8]  = '{1'b0, 5'b00000, 3'd3, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 3'd3};
        vecs[9]  = '{1'b0, 5'b00000, 3'd3, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000, 3'd3};
        vecs[10] = '{1'b0, 5'b10100, 3'd0, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b10100, 3'd3};
        vecs[11] = '{1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00100, 1'b0, 5'b10100, 3'd2};
        vecs[12] = '{1'b0, 5'b00000, 3'd0, 1'b1, 1'b0, 5'b00100, 1'b0, 5'b10100, 3'd2};
        vecs[13] = '{1'b0, 5'b00000, 3'd2, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b10000, 3'd2};
        vecs[14] = '{1'b0, 5'b00000, 3'd2, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b10000, 3'd2};
        vecs[15] = '{1'b0, 5'b00000, 3'd2, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b10000, 3'd2};
        vecs[16] = '{1'b0, 5'b00000, 3'd2, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b10000, 3'd2};
        vecs[17] = '{1'b0, 5'b00000, 3'd2, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b10000, 3'd2};
        vecs[18] = '{1'b0, 5'b00000, 3'd2, 1'b0, 1'b0, 5'b10000, 1'b0, 5'b10000, 3'd4};
        vecs[19] = '{1'b0, 5'b00010, 3'd2, 1'b1, 1'b0, 5'b10000, 1'b0, 5'b10010, 3'd4};
        vecs[20] = '{1'b0, 5'b00000, 3'd3, 1'b1, 1'b0, 5'b10000, 1'b0, 5'b10010, 3'd4};
        vecs[21] = '{1'b0, 5'b00000, 3'd4, 1'b1, 1'b0, 5'b10000, 1'b0, 5'b10010, 3'd4};
        vecs[22] = '{1'b0, 5'b00000, 3'd4, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010, 3'd4};
        vecs[23] = '{1'b0, 5'b00000, 3'd4, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010, 3'd4};
        vecs[24] = '{1'b0, 5'b00000, 3'd4, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010, 3'd4};
        vecs[25] = '{1'b0, 5'b00000, 3'd4, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00010, 3'd4};
        vecs[26] = '{1'b0, 5'b00000, 3'd4, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00010, 3'd4};
        vecs[27] = '{1'b0, 5'b00000, 3'd4, 1'b0, 1'b0, 5'b00010, 1'b0, 5'b00010, 3'd1};
        vecs[28] = '{1'b0, 5'b00000, 3'd3, 1'b0, 1'b1, 5'b00010, 1'b0, 5'b00010, 3'd1};
        vecs[29] = '{1'b0, 5'b00000, 3'd1, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 3'd1};
        vecs[30] = '{1'b0, 5'b00000, 3'd1, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 3'd1};
        vecs[31] = '{1'b0, 5'b00000, 3'd1, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 3'd1};
        vecs[32] = '{1'b0, 5'b00000, 3'd1, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 3'd1};
        vecs[33] = '{1'b0, 5'b00000, 3'd1, 1'b0, 1'b0, 5'b00000, 1'b0, 5'b00000, 3'd1};

        @(negedge clk);
        for (int i = 0; i < 34; i++) begin
            step(vecs[i].rst, vecs[i].b, vecs[i].fl, vecs[i].mu, vecs[i].md);
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_door, vecs[i].e_pend, vecs[i].e_tgt);
        end

        // Current-floor press on door cycle 3 extends the door by a full period.
        step(1, 5'b00000, 3'd2, 0, 0);
        step(0, 5'b00100, 3'd2, 0, 0);
        chk("ext.latch", 8'(pending), 8'b00100);
        step(0, 5'b00000, 3'd2, 0, 0);
        chk("ext.req", 8'(req), 8'b00100);
        step(0, 5'b00000, 3'd2, 0, 0);
        step(0, 5'b00000, 3'd2, 0, 0);
        step(0, 5'b00000, 3'd2, 0, 0);
        chk("ext.door3", 8'(door_open), 8'd1);
        step(0, 5'b00100, 3'd2, 0, 0);
        chk("ext.pend2", 8'(pending), 8'b00000);
        chk("ext.door_r", 8'(door_open), 8'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 5'b00000, 3'd2, 0, 0);
            chk($sformatf("ext.door+%0d", i + 1), 8'(door_open), 8'd1);
        end
        step(0, 5'b00000, 3'd2, 0, 0);
        chk("ext.closed", 8'(door_open), 8'd0);
        chk("ext.noreq", 8'(req), 8'd0);

        // Holding a button produces exactly one call.
        step(1, 5'b00000, 3'd1, 0, 0);
        dispatch_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 5'b00010, 3'd1, 0, 0);
            if (req != 5'b0) dispatch_cycles++;
        end
        chk("hold.dispatches", 8'(dispatch_cycles), 8'd1);
        chk("hold.pend", 8'(pending), 8'b00000);
        step(0, 5'b00000, 3'd1, 0, 0);
        chk("hold.req", 8'(req), 8'b00000);
        chk("hold.door", 8'(door_open), 8'd0);

        // Reset while dispatching clears everything.
        step(0, 5'b10110, 3'd0, 1, 0);
        chk("rst.pend", 8'(pending), 8'b10110);
        step(0, 5'b00000, 3'd0, 1, 0);
        chk("rst.req_pre", 8'(req), 8'b00010);
        step(1, 5'b00000, 3'd0, 1, 0);
        chk_all("rst.after", 5'b0, 1'b0, 5'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 5'b00000, 3'd0, 0, 0);
            chk($sformatf("rst.idle%0d.req", i), 8'(req), 8'd0);
            chk($sformatf("rst.idle%0d.pend", i), 8'(pending), 8'd0);
        end

        // Floors 5-7 never match; a press on the target in the serve cycle loses to the clear.
        step(0, 5'b00001, 3'd5, 0, 0);
        chk("oor.latch", 8'(pending), 8'b00001);
        for (int f = 5; f <= 7; f++) begin
            step(0, 5'b00000, 3'(f), 0, 0);
            chk($sformatf("oor.fl%0d.req", f), 8'(req), 8'b00001);
        end
        step(0, 5'b00001, 3'd0, 0, 0);
        chk("clr.door", 8'(door_open), 8'd1);
        chk("clr.pend", 8'(pending), 8'b00000);
        step(0, 5'b00000, 3'd0, 0, 0);
        chk("clr.pend2", 8'(pending), 8'b00000);

        // A button held through reset registers as a press on the first cycle after.
        step(1, 5'b10000, 3'd0, 0, 0);
        chk("first.rst_pend", 8'(pending), 8'b00000);
        step(0, 5'b10000, 3'd0, 0, 0);
        chk("first.pend", 8'(pending), 8'b10000);
        step(0, 5'b10000, 3'd0, 0, 0);
        chk("first.req", 8'(req), 8'b10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
